// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the two-stage DE/MW pipeline: peripheral wait, branch squash, debug halt, stall counter.
// Optional build macro PIPE_CTRL_TIMEOUT_EN adds the WAIT timeout counter and the bus_err pulse.
module pipeline_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_MW,
    input  logic             periph_sel,
    input  logic             mem_ack,
    input  logic             br_taken_MW,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             stall_IF,
    output logic             stall_DE,
    output logic             flush_DE,
    output logic             mem_req,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
            $error("pipeline_ctrl: TIMEOUT must be in 1..65535");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             halted_q;
    logic             access;
    logic             timeout_hit;
    logic             stall_if_c, stall_de_c, flush_de_c, mem_req_c;

    // Only loads (opcode 3) and stores (opcode 35) to the peripheral region wait on a handshake.
    assign access = periph_sel && ((instr_MW[6:0] == 7'd3) || (instr_MW[6:0] == 7'd35));

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        bus_err_q, bus_err_d;

    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_RUN) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // An ack arriving on the last allowed cycle still counts as a normal completion.
    assign bus_err_d = timeout_hit && !mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        stall_if_c = 1'b0;
        stall_de_c = 1'b0;
        flush_de_c = 1'b0;
        mem_req_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                mem_req_c = access;
                if (access && !mem_ack) begin
                    stall_if_c = 1'b1;
                    stall_de_c = 1'b1;
                    state_d    = ST_WAIT;
                end else begin
                    flush_de_c = br_taken_MW;
                    if (halt_req) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_WAIT: begin
                mem_req_c = 1'b1;
                if (mem_ack || timeout_hit) begin
                    state_d = halt_req ? ST_DRAIN : ST_RUN;
                end else begin
                    stall_if_c = 1'b1;
                    stall_de_c = 1'b1;
                end
            end
            ST_DRAIN: begin
                stall_if_c = 1'b1;
                flush_de_c = 1'b1;
                state_d    = ST_HALT;
            end
            default: begin
                stall_if_c = 1'b1;
                flush_de_c = 1'b1;
                if (resume_req) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Parked cycles are not stalls; only real pipeline holds are counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if_c && (state_q != ST_HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            halted_q    <= (state_d == ST_HALT);
        end
    end

    // Reset forces the controls low even when a peripheral access is still presented in MW.
    assign stall_IF  = rst_n & stall_if_c;
    assign stall_DE  = rst_n & stall_de_c;
    assign flush_DE  = rst_n & flush_de_c;
    assign mem_req   = rst_n & mem_req_c;
    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: reset checks, a directed vector table, reset/timeout sequences and a random run against a model.
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [31:0] I_ADD = 32'h0000_0033;
    localparam logic [31:0] I_LW  = 32'h0000_2003;
    localparam logic [31:0] I_SW  = 32'h0000_2023;
    localparam logic [31:0] I_BEQ = 32'h0000_0063;
    localparam logic [31:0] I_JAL = 32'h0000_006F;
    localparam logic [31:0] I_NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr_MW;
    logic             periph_sel, mem_ack, br_taken_MW, halt_req, resume_req;
    logic             stall_IF, stall_DE, flush_DE, mem_req, halted, bus_err;
    logic [CNT_W-1:0] stall_cnt;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr_MW(instr_MW), .periph_sel(periph_sel),
        .mem_ack(mem_ack), .br_taken_MW(br_taken_MW), .halt_req(halt_req),
        .resume_req(resume_req), .stall_IF(stall_IF), .stall_DE(stall_DE),
        .flush_DE(flush_DE), .mem_req(mem_req), .halted(halted), .bus_err(bus_err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = running, 1 = draining, 2 = parked.
    bit m_waiting;
    int m_waited;
    int m_phase;
    int m_cnt;
    bit m_halted;
    bit m_buserr;
    bit e_sif, e_sde, e_fl, e_mr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0; m_waited = 0; m_phase = 0; m_cnt = 0; m_halted = 0; m_buserr = 0;
    endtask

    function automatic bit is_access();
        return periph_sel && (instr_MW[6:0] == 7'd3 || instr_MW[6:0] == 7'd35);
    endfunction

    function automatic bit releases();
        return mem_ack || (TO_EN && m_waited == TIMEOUT - 1);
    endfunction

    task automatic model_predict();
        bit acc;
        acc = is_access();
        e_sif = 0; e_sde = 0; e_fl = 0; e_mr = 0;
        if (m_phase != 0) begin
            e_sif = 1; e_fl = 1;
        end else if (m_waiting) begin
            e_mr  = 1;
            e_sif = !releases();
            e_sde = !releases();
        end else begin
            e_mr = acc;
            if (acc && !mem_ack) begin
                e_sif = 1; e_sde = 1;
            end else begin
                e_fl = br_taken_MW;
            end
        end
    endtask

    task automatic model_advance();
        int  old_phase;
        bit  next_err;
        old_phase = m_phase;
        next_err  = 0;
        if (m_phase == 2) begin
            if (resume_req) m_phase = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_waiting) begin
            next_err = TO_EN && !mem_ack && (m_waited == TIMEOUT - 1);
            if (releases()) begin
                m_waiting = 0;
                if (halt_req) m_phase = 1;
            end else begin
                m_waited++;
            end
        end else if (is_access() && !mem_ack) begin
            m_waiting = 1;
            m_waited  = 0;
        end else if (halt_req) begin
            m_phase = 1;
        end
        if (e_sif && old_phase != 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_halted = (m_phase == 2);
        m_buserr = next_err;
    endtask

    task automatic settle_and_check();
        @(negedge clk);
        model_predict();
        check("stall_IF",  32'(stall_IF),  32'(e_sif));
        check("stall_DE",  32'(stall_DE),  32'(e_sde));
        check("flush_DE",  32'(flush_DE),  32'(e_fl));
        check("mem_req",   32'(mem_req),   32'(e_mr));
        check("halted",    32'(halted),    32'(m_halted));
        check("bus_err",   32'(bus_err),   32'(m_buserr));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic ps, input logic ack,
                         input logic br, input logic hr, input logic rr);
        instr_MW = ins; periph_sel = ps; mem_ack = ack;
        br_taken_MW = br; halt_req = hr; resume_req = rr;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        ps, ack, br, hr, rr;
        logic        sif, sde, fl, mr, hl, be;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // lw acked in its 4th cycle, zero-wait sw, taken beq, halt then resume.
        vecs[0]  = '{I_ADD, 0,0,0,0,0, 0,0,0,0,0,0, 4'd0};
        vecs[1]  = '{I_LW,  1,0,0,0,0, 1,1,0,1,0,0, 4'd0};
        vecs[2]  = '{I_LW,  1,0,0,0,0, 1,1,0,1,0,0, 4'd1};
        vecs[3]  = '{I_LW,  1,0,0,0,0, 1,1,0,1,0,0, 4'd2};
        vecs[4]  = '{I_LW,  1,1,0,0,0, 0,0,0,1,0,0, 4'd3};
        vecs[5]  = '{I_SW,  1,1,0,0,0, 0,0,0,1,0,0, 4'd3};
        vecs[6]  = '{I_BEQ, 0,0,1,0,0, 0,0,1,0,0,0, 4'd3};
        vecs[7]  = '{I_ADD, 0,0,0,1,0, 0,0,0,0,0,0, 4'd3};
        vecs[8]  = '{I_ADD, 0,0,0,0,0, 1,0,1,0,0,0, 4'd3};
        vecs[9]  = '{I_NOP, 0,0,0,0,0, 1,0,1,0,1,0, 4'd4};
        vecs[10] = '{I_NOP, 0,0,0,1,1, 1,0,1,0,1,0, 4'd4};
        vecs[11] = '{I_ADD, 0,0,0,0,0, 0,0,0,0,0,0, 4'd4};

        rst_n = 1'b0;
        drive(I_LW, 1, 0, 1, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst stall_IF",  32'(stall_IF),  0);
        check("rst stall_DE",  32'(stall_DE),  0);
        check("rst flush_DE",  32'(flush_DE),  0);
        check("rst mem_req",   32'(mem_req),   0);
        check("rst halted",    32'(halted),    0);
        check("rst bus_err",   32'(bus_err),   0);
        check("rst stall_cnt", 32'(stall_cnt), 0);
        drive(I_ADD, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ins, vecs[i].ps, vecs[i].ack, vecs[i].br, vecs[i].hr, vecs[i].rr);
            settle_and_check();
            check($sformatf("vec%0d stall_IF", i),  32'(stall_IF),  32'(vecs[i].sif));
            check($sformatf("vec%0d stall_DE", i),  32'(stall_DE),  32'(vecs[i].sde));
            check($sformatf("vec%0d flush_DE", i),  32'(flush_DE),  32'(vecs[i].fl));
            check($sformatf("vec%0d mem_req", i),   32'(mem_req),   32'(vecs[i].mr));
            check($sformatf("vec%0d halted", i),    32'(halted),    32'(vecs[i].hl));
            check($sformatf("vec%0d bus_err", i),   32'(bus_err),   32'(vecs[i].be));
            check($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].cnt));
            $display("vec %0d: instr=%08h sif=%0b sde=%0b fl=%0b mr=%0b halted=%0b cnt=%0d",
                     i, vecs[i].ins, stall_IF, stall_DE, flush_DE, mem_req, halted, stall_cnt);
            advance();
        end

        // Reset asserted during the second WAIT cycle of an unacked peripheral load.
        drive(I_LW, 1, 0, 0, 0, 0);
        settle_and_check();
        advance();
        settle_and_check();
        advance();
        #2;
        rst_n = 1'b0;
        #1;
        check("midwait mem_req",   32'(mem_req),   0);
        check("midwait stall_IF",  32'(stall_IF),  0);
        check("midwait stall_DE",  32'(stall_DE),  0);
        check("midwait stall_cnt", 32'(stall_cnt), 0);
        check("midwait halted",    32'(halted),    0);
        drive(I_ADD, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 12; c++) begin
            settle_and_check();
            check("post-reset bus_err", 32'(bus_err), 0);
            advance();
        end
        $display("reset mid-wait: sequence complete");

`ifdef PIPE_CTRL_TIMEOUT_EN
        begin : timeout_seq
            int st;
            int be;
            int be_at;
            st = 0; be = 0; be_at = -1;
            for (int c = 0; c < 13; c++) begin
                if (c <= 8) drive(I_LW, 1, 0, 0, 0, 0);
                else        drive(I_ADD, 0, 0, 0, 0, 0);
                settle_and_check();
                if (stall_IF) st++;
                if (bus_err) begin
                    be++;
                    be_at = c;
                end
                advance();
            end
            check("timeout stall cycles", 32'(st), 32'(TIMEOUT));
            check("timeout bus_err pulses", 32'(be), 1);
            check("timeout bus_err cycle", 32'(be_at), 32'(TIMEOUT + 1));
            $display("timeout: stalls=%0d bus_err_pulses=%0d at=%0d", st, be, be_at);
        end
`endif

        // Random instruction stream; an access is held in MW until it retires.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            logic        ps, ack, br;
            ins = I_ADD; ps = 0; br = 0;
            ack = 1'($urandom_range(0, 1));
            if (m_phase != 0) begin
                ins = I_NOP;
                br  = 1'($urandom_range(0, 1));
            end else if (m_waiting) begin
                ins = instr_MW;
                ps  = 1;
                ack = ($urandom_range(0, 3) == 0);
            end else begin
                case ($urandom_range(0, 5))
                    0: ins = I_ADD;
                    1: begin ins = I_LW; ps = 1; end
                    2: begin ins = I_SW; ps = 1; end
                    3: ins = I_LW;
                    4: begin ins = I_BEQ; br = 1'($urandom_range(0, 1)); end
                    default: begin ins = I_JAL; br = 1; end
                endcase
            end
            drive(ins, ps, ack, br, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
            settle_and_check();
            advance();
        end
        $display("random: 3000 cycles applied, stall_cnt=%0d", stall_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall and flush sequencer for the two-stage (DE/MW) RV32I pipeline with UART integration. It sits beside the forwarding hazard logic and owns the pipeline-register enables. It does four things: holds fetch/DE while a peripheral load/store in MW waits for its handshake, squashes the wrong-path instruction after a taken branch or jump, drains and parks the core on a debug halt request, and counts stall cycles.

## Interface
Parameters:
- TIMEOUT, 255: maximum MW wait cycles before a peripheral access is aborted. Range 1..65535.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- instr_MW  in  32  instruction currently in MW
- periph_sel  in  1  MW load/store address decodes to the UART/peripheral region
- mem_ack  in  1  peripheral completes the access this cycle
- br_taken_MW  in  1  MW branch is taken, or MW holds jal/jalr
- halt_req  in  1  debug halt request (level)
- resume_req  in  1  debug resume request (level)
- stall_IF  out  1  hold PC
- stall_DE  out  1  hold DE register
- flush_DE  out  1  load NOP (0x00000013) into DE on next edge
- mem_req  out  1  peripheral access strobe
- halted  out  1  core parked
- bus_err  out  1  one-cycle pulse on access timeout
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- access = periph_sel and (instr_MW[6:0] == 3 or instr_MW[6:0] == 35).
- FSM states: RUN, WAIT, DRAIN, HALT. Reset state is RUN.
- RUN:
  - mem_req = access.
  - If access and !mem_ack: stall_IF = stall_DE = 1, go to WAIT, clear wait counter.
  - If access and mem_ack: no stall; stay in RUN.
  - If br_taken_MW: flush_DE = 1.
  - If halt_req and not stalling: go to DRAIN.
- WAIT:
  - mem_req = 1 and stall_IF = stall_DE = 1, except in the release cycle (below), where both stalls are 0.
  - The wait counter increments each cycle.
  - Release on mem_ack, or on counter == TIMEOUT-1 when the timeout feature is compiled in. The release cycle behaves as RUN: stalls drop and the MW instruction retires.
  - After release, go to DRAIN if halt_req, otherwise RUN.
- DRAIN (one cycle): stall_IF = 1 and flush_DE = 1, so the DE instruction advances to MW and a NOP enters DE. Go to HALT.
- HALT:
  - stall_IF = 1, flush_DE = 1, halted = 1.
  - MW only ever sees NOPs, so mem_req is 0.
  - resume_req = 1 returns to RUN with all controls 0 on the next cycle. resume_req wins over a simultaneous halt_req.
- Stall/flush priority:
  - stall_DE and flush_DE are never both 1.
  - A taken branch in MW cannot coincide with an access, because the opcodes are disjoint. br_taken_MW during DRAIN/HALT is ignored.
- stall_cnt increments in every cycle with stall_IF = 1 and state != HALT. It saturates at all-ones.

## Timing
- Reset (rst_n = 0, asynchronous): state RUN; wait counter 0; stall_cnt 0; halted 0; bus_err 0.
- stall_IF, stall_DE, flush_DE and mem_req are combinational from state and inputs; all are 0 under reset.
- Zero-wait access: mem_ack in the same cycle as access gives 0 stall cycles.
- Access acked N cycles after MW entry: exactly N stall cycles.
- Timeout: release occurs TIMEOUT cycles after entering WAIT. bus_err is registered and high for exactly the cycle after release.
- Halt latency: halted rises 2 cycles after halt_req is sampled in RUN with no access pending.
- Resume latency: the PC advances in the cycle after resume_req is sampled.
- Reset mid-WAIT: the access is abandoned, mem_req drops immediately, and no bus_err is produced.

## Configuration
- PIPE_CTRL_TIMEOUT_EN defined: the wait counter and the bus_err pulse are built, and a WAIT with no ack releases after TIMEOUT cycles.
- PIPE_CTRL_TIMEOUT_EN undefined: WAIT releases only on mem_ack, and bus_err is tied to 0. TIMEOUT is ignored, and the wait counter is neither built nor used.

## Test plan
- lw with periph_sel = 1 and mem_ack raised on the 4th cycle: stall_IF/stall_DE high for exactly 3 cycles, mem_req high for 4 cycles, stall_cnt = 3.
- sw with periph_sel = 1 and mem_ack in the same cycle: no stall, mem_req high for 1 cycle.
- beq taken in MW: flush_DE = 1 for one cycle, and DE holds 0x00000013 after the edge.
- halt_req pulsed while MW holds an add: DRAIN then HALT, halted = 1 two cycles later. resume_req = 1 then gives halted = 0 with the PC incrementing the next cycle.
- PIPE_CTRL_TIMEOUT_EN with TIMEOUT = 8 and no mem_ack: 8 stall cycles, bus_err high for exactly one cycle, then return to RUN.
- rst_n dropped in the 2nd WAIT cycle: all outputs 0 asynchronously, stall_cnt = 0, no bus_err after rst_n releases.
